// File: rtl/uart_tx_framed_pkg.sv
// Shared definitions for the framed UART transmitter.
//   state_t       : transmitter FSM state encoding
//   PARITY_*      : parity mode codes used by the PARITY parameter
//   B*            : CLK_DIV values for common baud rates at a 12 MHz clock
//   parity_bit()  : parity bit for a zero-extended data word
package uart_tx_framed_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Divisors for a 12 MHz system clock.
  localparam int B9600   = 1250;
  localparam int B19200  = 625;
  localparam int B38400  = 313;
  localparam int B57600  = 208;
  localparam int B115200 = 104;

  localparam int MAX_DATA_BITS = 9;

  // Unused upper bits of word must be zero. Odd mode makes the total count of
  // ones (data + parity) odd, even mode makes it even.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] word,
                                      input int mode);
    return (mode == PARITY_ODD) ? ~(^word) : (^word);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: emits a single-cycle tick every CLK_DIV clk cycles.
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   clear : hold the count at 0 (no tick) while asserted; counting restarts
//           from 0 on the first cycle after clear drops
//   tick  : high on the last cycle of each CLK_DIV-cycle bit period
module uart_baud_tick #(
  parameter int CLK_DIV = 1250
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: flops are written with non-blocking assignments so every register
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter with a one-word holding register in front of the
// shift register, so a new word can be accepted while a frame is on the line.
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   valid : data holds a word to send
//   data  : word to transmit, LSB first
//   ready : registered; holding register empty, word accepted if valid=1
//   busy  : a frame is in progress (FSM not idle)
//   tx    : registered serial output, idle high
module uart_tx_framed
  import uart_tx_framed_pkg::*;
#(
  parameter int CLK_DIV   = 1250,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx
);

  state_t                 state;
  state_t                 state_next;
  logic                   tick;
  logic                   baud_clear;
  logic                   accept;
  logic                   load;
  logic                   shift_en;
  logic                   tx_next;
  logic                   last_data;
  logic                   last_stop;
  logic [3:0]             bit_cnt;
  logic                   hold_full;
  logic                   hold_full_next;
  logic [DATA_BITS-1:0]   hold_data;
  logic [MAX_DATA_BITS-1:0] hold_ext;
  logic [DATA_BITS-1:0]   shifter;
  logic                   par_q;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .rstn  (rstn),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign accept    = valid && ready;
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    unique case (state)
      ST_IDLE:  if (hold_full) state_next = ST_START;
      ST_START: if (tick) state_next = ST_DATA;
      ST_DATA:  if (tick && last_data)
                  state_next = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:   if (tick) state_next = ST_STOP;
      ST_STOP:  if (tick && last_stop)
                  state_next = hold_full ? ST_START : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / control decode. The baud counter is held at 0 while idle, so a
  // frame started from idle always gets full-length bit times regardless of
  // when the word arrived; back-to-back frames continue the counter, which
  // wraps to 0 exactly at the frame boundary.
  always_comb begin
    tx_next    = 1'b1;
    load       = 1'b0;
    shift_en   = 1'b0;
    baud_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        baud_clear = 1'b1;
        load       = hold_full;
      end
      ST_START: tx_next = 1'b0;
      ST_DATA: begin
        tx_next  = shifter[0];
        shift_en = tick;
      end
      ST_PAR:  tx_next = par_q;
      ST_STOP: load = tick && last_stop && hold_full;
      default: tx_next = 1'b1;
    endcase
  end

  // Bit counter within DATA and STOP; restarts on every state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
    end else if (state != state_next) begin
      bit_cnt <= '0;
    end else if (tick && ((state == ST_DATA) || (state == ST_STOP))) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Holding register. An accept in the same cycle the holding word drains to
  // the shifter keeps the new word, so hold_full stays set and ready stays low.
  assign hold_full_next = accept || (hold_full && !load);

  // NOTE: the data registers are reset along with the control flops; it is
  // cheap at this size and keeps tx and the parity bit free of X after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_full <= 1'b0;
      ready     <= 1'b1;
      hold_data <= '0;
    end else begin
      hold_full <= hold_full_next;
      ready     <= !hold_full_next;
      if (accept) hold_data <= data;
    end
  end

  always_comb begin
    hold_ext                = '0;
    hold_ext[DATA_BITS-1:0] = hold_data;
  end

  // Shift register and parity, captured together when a frame starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shifter <= '0;
      par_q   <= 1'b1;
    end else if (load) begin
      shifter <= hold_data;
      par_q   <= parity_bit(hold_ext, PARITY);
    end else if (shift_en) begin
      shifter <= shifter >> 1;
    end
  end

  // tx is registered, so it trails the FSM state by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed. Four instances cover the frame
// formats: u0 8E1 (div 4), u1 8O1 (div 4), u2 7N1 (div 5), u3 8N2 (div 3).
// Drivers push the expected frame (built from the framing rules) into a
// per-instance queue; per-instance monitors sample tx every falling edge,
// rebuild each frame and compare it with the queue head.
module tb_uart_tx_framed;

  localparam int DIVS [4] = '{4, 4, 5, 3};
  localparam int NBS  [4] = '{8, 8, 7, 8};
  localparam int PMS  [4] = '{2, 1, 0, 0};
  localparam int SBS  [4] = '{1, 1, 1, 2};

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic        clk;
  logic [3:0]  rstn_v;
  logic [3:0]  valid_v;
  logic [8:0]  data_v [4];
  logic [3:0]  ready_v;
  logic [3:0]  busy_v;
  logic [3:0]  tx_v;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt [4];
  frame_t      exp_q [4][$];
  int          start_q [4][$];

  uart_tx_framed #(.CLK_DIV(DIVS[0]), .DATA_BITS(NBS[0]), .PARITY(PMS[0]), .STOP_BITS(SBS[0])) u0 (
    .clk(clk), .rstn(rstn_v[0]), .valid(valid_v[0]), .data(data_v[0][7:0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
  uart_tx_framed #(.CLK_DIV(DIVS[1]), .DATA_BITS(NBS[1]), .PARITY(PMS[1]), .STOP_BITS(SBS[1])) u1 (
    .clk(clk), .rstn(rstn_v[1]), .valid(valid_v[1]), .data(data_v[1][7:0]),
    .ready(ready_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
  uart_tx_framed #(.CLK_DIV(DIVS[2]), .DATA_BITS(NBS[2]), .PARITY(PMS[2]), .STOP_BITS(SBS[2])) u2 (
    .clk(clk), .rstn(rstn_v[2]), .valid(valid_v[2]), .data(data_v[2][6:0]),
    .ready(ready_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
  uart_tx_framed #(.CLK_DIV(DIVS[3]), .DATA_BITS(NBS[3]), .PARITY(PMS[3]), .STOP_BITS(SBS[3])) u3 (
    .clk(clk), .rstn(rstn_v[3]), .valid(valid_v[3]), .data(data_v[3][7:0]),
    .ready(ready_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input int idx);
    return 1 + NBS[idx] + ((PMS[idx] != 0) ? 1 : 0) + SBS[idx];
  endfunction

  // Expected frame in time order: bit 0 of .bits is the first bit on the line.
  function automatic frame_t build_frame(input int idx, input logic [8:0] d);
    frame_t f;
    int     pos;
    int     ones;
    f.bits = '0;
    pos    = 1;
    ones   = 0;
    for (int i = 0; i < NBS[idx]; i++) begin
      f.bits[pos] = d[i];
      if (d[i]) ones++;
      pos++;
    end
    if (PMS[idx] == 1) begin
      f.bits[pos] = ((ones % 2) == 0);
      pos++;
    end else if (PMS[idx] == 2) begin
      f.bits[pos] = ((ones % 2) == 1);
      pos++;
    end
    for (int i = 0; i < SBS[idx]; i++) begin
      f.bits[pos] = 1'b1;
      pos++;
    end
    f.len = pos;
    return f;
  endfunction

  // Offers d on instance idx until accepted; acc returns the cycle number of
  // the accepting rising edge. valid is left high for back-to-back sends.
  task automatic send(input int idx, input logic [8:0] d, output int acc);
    int guard;
    guard = 0;
    acc   = -1;
    @(negedge clk);
    valid_v[idx] = 1'b1;
    data_v[idx]  = d;
    while (ready_v[idx] !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (ready_v[idx] !== 1'b1) begin
      check($sformatf("accept timeout u%0d", idx), ready_v[idx], 1);
      valid_v[idx] = 1'b0;
    end else begin
      exp_q[idx].push_back(build_frame(idx, d));
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic release_valid(input int idx);
    @(negedge clk);
    valid_v[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int target);
    int guard;
    guard = 0;
    while (done_cnt[idx] < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("frames received u%0d", idx), done_cnt[idx], target);
  endtask

  task automatic monitor(input int idx);
    int          d;
    int          n;
    int          bad;
    int          start;
    logic [15:0] bits;
    bit          aborted;
    frame_t      e;
    d = DIVS[idx];
    n = frame_len(idx);
    forever begin
      @(negedge clk);
      if (rstn_v[idx] === 1'b1 && tx_v[idx] === 1'b0) begin
        start   = cyc;
        bits    = '0;
        bad     = 0;
        aborted = 1'b0;
        for (int s = 0; s < n * d; s++) begin
          if (s != 0) @(negedge clk);
          if (rstn_v[idx] !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if ((s % d) == 0) bits[s / d] = tx_v[idx];
          else if (tx_v[idx] !== bits[s / d]) bad++;
        end
        if (aborted) begin
          // Reset drops the frame in flight and any held word.
          exp_q[idx].delete();
        end else begin
          start_q[idx].push_back(start);
          check($sformatf("frame was expected u%0d", idx), exp_q[idx].size() != 0, 1);
          if (exp_q[idx].size() != 0) begin
            e = exp_q[idx].pop_front();
            check($sformatf("frame bits u%0d", idx), bits, e.bits);
          end
          check($sformatf("bit held %0d cycles u%0d", d, idx), bad, 0);
          done_cnt[idx]++;
        end
      end
    end
  endtask

  task automatic rand_stream(input int idx, input int count);
    int acc;
    int gap;
    for (int i = 0; i < count; i++) begin
      send(idx, 9'($urandom_range(0, 511)), acc);
      gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40);
      if (gap != 0) begin
        release_valid(idx);
        repeat (gap) @(negedge clk);
      end
    end
    release_valid(idx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int base;
    int guard;
    int ns;

    for (int i = 0; i < 4; i++) begin
      done_cnt[i] = 0;
      data_v[i]   = '0;
    end
    valid_v = '0;
    rstn_v  = 4'hF;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    // Reset applies without any clock edge.
    #1 rstn_v = 4'h0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset tx u%0d", i), tx_v[i], 1);
      check($sformatf("reset ready u%0d", i), ready_v[i], 1);
      check($sformatf("reset busy u%0d", i), busy_v[i], 0);
    end
    repeat (3) @(negedge clk);
    rstn_v = 4'hF;
    repeat (2) @(negedge clk);

    // 8E1, div 4: 0xA5, two-cycle accept-to-start latency, 44-cycle frame.
    send(0, 9'h0A5, acc);
    release_valid(0);
    wait_done(0, 1);
    check("A5 start latency", start_q[0][$] - acc, 2);
    check("A5 busy after frame", busy_v[0], 0);
    check("A5 ready after frame", ready_v[0], 1);

    // Odd parity on all zeros; 7N1 all ones.
    send(1, 9'h000, acc);
    release_valid(1);
    wait_done(1, 1);
    send(2, 9'h07F, acc);
    release_valid(2);
    wait_done(2, 1);
    check("7N1 start latency", start_q[2][$] - acc, 2);

    // Two stop bits: next start edge exactly one frame (11 bits x 3) later.
    send(3, 9'h055, acc);
    send(3, 9'h0F0, acc);
    release_valid(3);
    wait_done(3, 2);
    check("8N2 back-to-back spacing", start_q[3][1] - start_q[3][0], 33);

    // Valid held high across three words: no idle gap, ready low when full.
    base = done_cnt[0];
    ns   = start_q[0].size();
    send(0, 9'h011, acc);
    send(0, 9'h022, acc);
    check("ready low after 2nd accept", ready_v[0], 0);
    send(0, 9'h033, acc);
    release_valid(0);
    wait_done(0, base + 3);
    check("gap frame1-frame2", start_q[0][ns + 1] - start_q[0][ns], 44);
    check("gap frame2-frame3", start_q[0][ns + 2] - start_q[0][ns + 1], 44);
    repeat (60) @(negedge clk);
    check("each word sent once", done_cnt[0], base + 3);

    // A word offered while ready is low is ignored.
    base = done_cnt[0];
    send(0, 9'h012, acc);
    send(0, 9'h034, acc2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      data_v[0] = 9'h0FF;
      check("ready low while held", ready_v[0], 0);
    end
    release_valid(0);
    wait_done(0, base + 2);
    repeat (60) @(negedge clk);
    check("0xFF not accepted", done_cnt[0], base + 2);
    check("idle after held word", busy_v[0], 0);

    // Reset during data bit 3, then a clean frame.
    base = done_cnt[0];
    send(0, 9'h0C3, acc);
    release_valid(0);
    guard = 0;
    while (tx_v[0] !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("start bit before reset", tx_v[0], 0);
    repeat (4 * DIVS[0]) @(negedge clk);
    #2 rstn_v[0] = 1'b0;
    #1;
    check("mid-frame reset tx", tx_v[0], 1);
    check("mid-frame reset ready", ready_v[0], 1);
    check("mid-frame reset busy", busy_v[0], 0);
    repeat (3) @(negedge clk);
    rstn_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 9'h03C, acc);
    release_valid(0);
    wait_done(0, base + 1);
    check("3C start latency after reset", start_q[0][$] - acc, 2);

    // Random traffic on every format, with and without gaps.
    fork
      rand_stream(0, 12);
      rand_stream(1, 10);
      rand_stream(2, 10);
      rand_stream(3, 10);
    join

    guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (80) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("scoreboard drained u%0d", i), exp_q[i].size(), 0);
      check($sformatf("idle at end u%0d", i), busy_v[i], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
